// File: rtl/w5300_bus_master_pkg.sv
// Shared op encodings, FSM state constants and default bus timing for the W5300 bus master.
package w5300_bus_master_pkg;

    localparam logic       OP_WR   = 1'b1;
    localparam logic       OP_RD   = 1'b0;
    localparam logic [9:0] IR_ADDR = 10'h002;

    localparam int RST_LOW_CYC_DEF  = 200;
    localparam int RST_WAIT_CYC_DEF = 1_000_000;
    localparam int SETUP_CYC_DEF    = 2;
    localparam int STROBE_CYC_DEF   = 5;
    localparam int HOLD_CYC_DEF     = 1;
    localparam int RECOVER_CYC_DEF  = 3;

    typedef logic [2:0] bus_state_t;
    localparam bus_state_t ST_RST_LOW  = 3'd0;
    localparam bus_state_t ST_RST_WAIT = 3'd1;
    localparam bus_state_t ST_IDLE     = 3'd2;
    localparam bus_state_t ST_SETUP    = 3'd3;
    localparam bus_state_t ST_STROBE   = 3'd4;
    localparam bus_state_t ST_RECOVER  = 3'd5;
    localparam bus_state_t ST_HOLD     = 3'd6;

    typedef struct packed {
        bus_state_t state;
        logic       int_pend;
    } bus_dbg_t;

    function automatic int max6(input int a, input int b, input int c,
                                input int d, input int e, input int f);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        if (f > m) m = f;
        return m;
    endfunction

endpackage

// File: rtl/w5300_bus_master_int_sync.sv
// Two-flop synchronizer for the W5300 interrupt pin plus a falling-edge detector.
module w5300_int_sync (
    input  logic clk,
    input  logic rst,
    input  logic int_n_i,
    output logic int_lvl_n_o,
    output logic int_fall_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], int_n_i};
    end

    // Idle level of the pin is high, so reset to "no interrupt".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign int_lvl_n_o = sync_q[1];
    assign int_fall_o  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/w5300_bus_master.sv
// W5300 direct-mode 16-bit bus master: chip reset sequencing plus timed single register accesses.
// Optional interrupt synchronizer and sticky flag enabled by W5300_INT_SYNC_EN.
module w5300_bus_master
    import w5300_bus_master_pkg::*;
#(
    parameter int RST_LOW_CYC  = RST_LOW_CYC_DEF,
    parameter int RST_WAIT_CYC = RST_WAIT_CYC_DEF,
    parameter int SETUP_CYC    = SETUP_CYC_DEF,
    parameter int STROBE_CYC   = STROBE_CYC_DEF,
    parameter int HOLD_CYC     = HOLD_CYC_DEF,
    parameter int RECOVER_CYC  = RECOVER_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    input  logic        enable,
    input  logic [10:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        op_state,
    output logic        busy,
    output logic        w5300_rst_n,
    output logic [9:0]  w5300_addr,
    output logic [15:0] w5300_data_o,
    output logic        w5300_data_oe,
    input  logic [15:0] w5300_data_i,
    output logic        w5300_cs_n,
    output logic        w5300_wr_n,
    output logic        w5300_rd_n,
    input  logic        w5300_int_n,
    output logic        irq,
    output bus_dbg_t    dbg
);

    localparam int MAX_CYC = max6(RST_LOW_CYC, RST_WAIT_CYC, SETUP_CYC,
                                  STROBE_CYC, HOLD_CYC, RECOVER_CYC);
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] RST_LOW_LD  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RST_WAIT_LD = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD    = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD   = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD     = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD  = CNT_W'(RECOVER_CYC - 1);

    bus_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             rst_n_q, rst_n_d;
    logic             op_q, op_d;
    logic [9:0]       bus_addr_q, bus_addr_d;
    logic [15:0]      data_o_q, data_o_d;
    logic             oe_q, oe_d;
    logic             cs_n_q, cs_n_d;
    logic             wr_n_q, wr_n_d;
    logic             rd_n_q, rd_n_d;
    logic             busy_q, busy_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic             op_state_q, op_state_d;
    logic             cnt_zero;
    logic             int_pend;

    // Handshake: enable is sampled only in Idle (which implies ready=1); addr/wr_data are
    // captured on that edge and ignored afterwards; op_state pulses exactly once per access.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        rst_n_d    = rst_n_q;
        op_d       = op_q;
        bus_addr_d = bus_addr_q;
        data_o_d   = data_o_q;
        oe_d       = oe_q;
        cs_n_d     = cs_n_q;
        wr_n_d     = wr_n_q;
        rd_n_d     = rd_n_q;
        busy_d     = busy_q;
        rd_data_d  = rd_data_q;
        cnt_zero   = (cnt_q == '0);

        unique case (state_q)
            ST_RST_LOW: begin
                if (cnt_zero) begin
                    state_d = ST_RST_WAIT;
                    cnt_d   = RST_WAIT_LD;
                    rst_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_SETUP;
                    cnt_d      = SETUP_LD;
                    op_d       = addr[10];
                    bus_addr_d = addr[9:0];
                    data_o_d   = wr_data;
                    cs_n_d     = 1'b0;
                    oe_d       = (addr[10] == OP_WR);
                    busy_d     = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                    wr_n_d  = (op_q != OP_WR);
                    rd_n_d  = (op_q == OP_WR);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    wr_n_d  = 1'b1;
                    rd_n_d  = 1'b1;
                    if (op_q == OP_RD) rd_data_d = w5300_data_i;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_RECOVER;
                    cnt_d   = RECOVER_LD;
                    cs_n_d  = 1'b1;
                    oe_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RECOVER: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RST_LOW;
                cnt_d   = RST_LOW_LD;
                ready_d = 1'b0;
                rst_n_d = 1'b0;
                oe_d    = 1'b0;
                cs_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                rd_n_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Registered so the pulse lands on the final Hold cycle.
        op_state_d = (state_d == ST_HOLD) && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RST_LOW;
            cnt_q      <= RST_LOW_LD;
            ready_q    <= 1'b0;
            rst_n_q    <= 1'b0;
            op_q       <= OP_RD;
            bus_addr_q <= '0;
            data_o_q   <= '0;
            oe_q       <= 1'b0;
            cs_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            rd_data_q  <= '0;
            op_state_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            rst_n_q    <= rst_n_d;
            op_q       <= op_d;
            bus_addr_q <= bus_addr_d;
            data_o_q   <= data_o_d;
            oe_q       <= oe_d;
            cs_n_q     <= cs_n_d;
            wr_n_q     <= wr_n_d;
            rd_n_q     <= rd_n_d;
            busy_q     <= busy_d;
            rd_data_q  <= rd_data_d;
            op_state_q <= op_state_d;
        end
    end

`ifdef W5300_INT_SYNC_EN
    logic int_lvl_n;
    logic int_fall;
    logic int_pend_q, int_pend_d;

    w5300_int_sync u_int_sync (
        .clk         (clk),
        .rst         (rst),
        .int_n_i     (w5300_int_n),
        .int_lvl_n_o (int_lvl_n),
        .int_fall_o  (int_fall)
    );

    // A new falling edge wins over a simultaneous IR read completion.
    always_comb begin
        int_pend_d = int_pend_q;
        if (op_state_q && (op_q == OP_RD) && (bus_addr_q == IR_ADDR)) int_pend_d = 1'b0;
        if (int_fall) int_pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_pend_q <= 1'b0;
        end else begin
            int_pend_q <= int_pend_d;
        end
    end

    assign int_pend = int_pend_q;
    assign irq      = ready_q & ~int_lvl_n;
`else
    logic int_unused;
    assign int_unused = w5300_int_n;
    assign int_pend   = 1'b0;
    assign irq        = 1'b0;
`endif

    assign ready         = ready_q;
    assign rd_data       = rd_data_q;
    assign op_state      = op_state_q;
    assign busy          = busy_q;
    assign w5300_rst_n   = rst_n_q;
    assign w5300_addr    = bus_addr_q;
    assign w5300_data_o  = data_o_q;
    assign w5300_data_oe = oe_q;
    assign w5300_cs_n    = cs_n_q;
    assign w5300_wr_n    = wr_n_q;
    assign w5300_rd_n    = rd_n_q;

    always_comb begin
        dbg.state    = state_q;
        dbg.int_pend = int_pend;
    end

endmodule

// File: tb/tb_w5300_bus_master.sv
// Randomized bench for w5300_bus_master: bus-level monitor against an expected-access queue.
module tb_w5300_bus_master;
  import w5300_bus_master_pkg::*;

  localparam int RST_LOW  = 4;
  localparam int RST_WAIT = 10;
  localparam int SETUP    = 2;
  localparam int STROBE   = 5;
  localparam int HOLD     = 1;
  localparam int RECOVER  = 3;
  localparam int W        = 43;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        enable;
  logic [10:0] addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        op_state;
  logic        busy;
  logic        w5300_rst_n;
  logic [9:0]  w5300_addr;
  logic [15:0] w5300_data_o;
  logic        w5300_data_oe;
  logic [15:0] w5300_data_i = 16'h0;
  logic        w5300_cs_n;
  logic        w5300_wr_n;
  logic        w5300_rd_n;
  logic        w5300_int_n;
  logic        irq;
  bus_dbg_t    dbg;

  w5300_bus_master #(
    .RST_LOW_CYC (RST_LOW),
    .RST_WAIT_CYC(RST_WAIT),
    .SETUP_CYC   (SETUP),
    .STROBE_CYC  (STROBE),
    .HOLD_CYC    (HOLD),
    .RECOVER_CYC (RECOVER)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .enable       (enable),
    .addr         (addr),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .op_state     (op_state),
    .busy         (busy),
    .w5300_rst_n  (w5300_rst_n),
    .w5300_addr   (w5300_addr),
    .w5300_data_o (w5300_data_o),
    .w5300_data_oe(w5300_data_oe),
    .w5300_data_i (w5300_data_i),
    .w5300_cs_n   (w5300_cs_n),
    .w5300_wr_n   (w5300_wr_n),
    .w5300_rd_n   (w5300_rd_n),
    .w5300_int_n  (w5300_int_n),
    .irq          (irq),
    .dbg          (dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];   // {op, addr[9:0], wr_data, read value to return}
  int n_checks = 0;
  int n_pass   = 0;
  int n_issued = 0;
  logic [15:0] last_rd = 16'h0;
  logic [15:0] rd_val_drv = 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Chip model: returns the current read value while RD_n is low, junk otherwise.
  always @(negedge clk) begin
    w5300_data_i = (!w5300_rd_n) ? rd_val_drv : 16'($urandom);
  end

  // ---------------- bus monitor ----------------
  int op_state_cnt = 0;
  int both_low = 0;
  int strobe_no_cs = 0;
  int oe_idle = 0;
  bit in_acc = 0;
  bit have_prev = 0;
  int gap = 0;
  int cs_len, wr_len, rd_len, oe_cnt, pre_len, unstable;
  logic [9:0]  acc_addr;
  logic [15:0] acc_data;
  logic [W-1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      in_acc = 0;
      have_prev = 0;
      gap = 0;
    end else begin
      if (op_state) op_state_cnt++;
      if (!w5300_wr_n && !w5300_rd_n) both_low++;
      if (w5300_cs_n) begin
        if (w5300_data_oe) oe_idle++;
        if (!w5300_wr_n || !w5300_rd_n) strobe_no_cs++;
        if (in_acc) begin
          in_acc = 0;
          have_prev = 1;
          gap = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_access", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("acc_op", 32'(wr_len > 0), 32'(e[42]));
            check("acc_addr", 32'(acc_addr), 32'(e[41:32]));
            if (e[42] == OP_WR) check("acc_wdata", 32'(acc_data), 32'(e[31:16]));
            check("setup_len", pre_len, SETUP);
            check("strobe_len", wr_len + rd_len, STROBE);
            check("cs_len", cs_len, SETUP + STROBE + HOLD);
            check("oe_cycles", oe_cnt, (e[42] == OP_WR) ? SETUP + STROBE + HOLD : 0);
            check("bus_stable", unstable, 0);
          end
        end
        gap++;
      end else begin
        if (!in_acc) begin
          in_acc = 1;
          if (have_prev) check("recover_gap", 32'(gap >= RECOVER), 32'd1);
          cs_len = 0; wr_len = 0; rd_len = 0; oe_cnt = 0; pre_len = -1; unstable = 0;
          acc_addr = w5300_addr;
          acc_data = w5300_data_o;
        end
        if (pre_len < 0 && (!w5300_wr_n || !w5300_rd_n)) pre_len = cs_len;
        cs_len++;
        if (!w5300_wr_n) wr_len++;
        if (!w5300_rd_n) rd_len++;
        if (w5300_data_oe) oe_cnt++;
        if (w5300_addr != acc_addr) unstable++;
        if (w5300_data_oe && w5300_data_o != acc_data) unstable++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    int n_low;
    int n_wait;
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_op_busy", 32'({op_state, busy}), 32'd0);
    check("rst_chip_rst_n", 32'(w5300_rst_n), 32'd0);
    check("rst_bus_addr_data", 32'({w5300_addr, w5300_data_o}), 32'd0);
    check("rst_oe", 32'(w5300_data_oe), 32'd0);
    check("rst_strobes", 32'({w5300_cs_n, w5300_wr_n, w5300_rd_n}), 32'b111);
    check("rst_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    enable = 1'b1;                  // must be ignored until ready
    addr = 11'($urandom);
    wr_data = 16'($urandom);
    n_low = 0;
    @(negedge clk);
    while (w5300_rst_n == 1'b0 && n_low < 1000) begin
      n_low++;
      @(negedge clk);
    end
    check("rst_low_cycles", n_low, RST_LOW);
    check("irq_not_ready", 32'(irq), 32'd0);
    n_wait = 0;
    while (ready == 1'b0 && n_wait < 1000) begin
      n_wait++;
      @(negedge clk);
    end
    enable = 1'b0;
    check("rst_wait_cycles", n_wait, RST_WAIT);
    check("busy_after_reset", 32'(busy), 32'd0);
    last_rd = 16'h0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || !ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 32'(!busy && ready), 32'd1);
  endtask

  task automatic wait_op(input int start, output int lat);
    bit seen;
    seen = 0;
    lat = start;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (op_state) seen = 1;
    end
    check("op_state_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_result(input logic op, input logic [15:0] rv);
    if (op == OP_RD) begin
      check("rd_data", 32'(rd_data), 32'(rv));
      last_rd = rv;
    end else begin
      check("rd_data_kept", 32'(rd_data), 32'(last_rd));
    end
  endtask

  task automatic single_access(input logic op, input logic [9:0] a,
                               input logic [15:0] d, input logic [15:0] rv);
    int lat;
    wait_idle();
    rd_val_drv = rv;
    enable = 1'b1;
    addr = {op, a};
    wr_data = d;
    exp_q.push_back({op, a, d, rv});
    n_issued++;
    @(posedge clk);
    #1;
    enable = 1'b0;
    addr = 11'($urandom);
    wr_data = 16'($urandom);
    wait_op(1, lat);
    check("latency", lat, 1 + SETUP + STROBE + HOLD);
    check_result(op, rv);
  endtask

  task automatic back_to_back(input int n);
    logic        op_a[4];
    logic [9:0]  a_a[4];
    logic [15:0] d_a[4];
    logic [15:0] rv_a[4];
    logic [9:0]  base;
    int lat;
    base = 10'($urandom_range(0, 1023));
    for (int i = 0; i < n; i++) begin
      op_a[i] = 1'($urandom_range(0, 1));
      a_a[i]  = base + 10'(2 * i);
      d_a[i]  = 16'($urandom);
      rv_a[i] = 16'($urandom);
      exp_q.push_back({op_a[i], a_a[i], d_a[i], rv_a[i]});
      n_issued++;
    end
    wait_idle();
    enable = 1'b1;
    addr = {op_a[0], a_a[0]};
    wr_data = d_a[0];
    rd_val_drv = rv_a[0];
    for (int i = 0; i < n; i++) begin
      wait_op((i == 0) ? 1 : 0, lat);
      check("btb_latency", lat, (i == 0) ? (1 + SETUP + STROBE + HOLD)
                                         : (RECOVER + 1 + SETUP + STROBE + HOLD));
      check_result(op_a[i], rv_a[i]);
      @(posedge clk);
      #1;
      if (i < n - 1) begin
        addr = {op_a[i+1], a_a[i+1]};
        wr_data = d_a[i+1];
        rd_val_drv = rv_a[i+1];
      end else begin
        enable = 1'b0;
      end
    end
  endtask

  task automatic abort_write();
    bit hit;
    int ops_before;
    wait_idle();
    enable = 1'b1;
    addr = {OP_WR, 10'($urandom)};
    wr_data = 16'($urandom);
    @(posedge clk);
    #1;
    enable = 1'b0;
    hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk);
      if (!w5300_wr_n) hit = 1;
    end
    check("abort_strobe_seen", 32'(hit), 32'd1);
    @(negedge clk);
    ops_before = op_state_cnt;
    #1;
    rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(w5300_cs_n), 32'd1);
    check("abort_wr_n", 32'(w5300_wr_n), 32'd1);
    check("abort_oe", 32'(w5300_data_oe), 32'd0);
    check("abort_chip_rst", 32'(w5300_rst_n), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    do_reset();
    check("abort_no_op_state", op_state_cnt, ops_before);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    enable = 1'b0;
    addr = '0;
    wr_data = '0;
    w5300_int_n = 1'b1;

    do_reset();

    single_access(OP_WR, 10'h000, 16'h0001, 16'h0000);
    single_access(OP_RD, 10'h208, 16'h0000, 16'h0013);
    back_to_back(3);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0)
        single_access(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                      16'($urandom), 16'($urandom));
      else
        back_to_back($urandom_range(2, 3));
    end

    abort_write();
    single_access(OP_RD, 10'($urandom_range(0, 1023)), 16'h0, 16'($urandom));

    wait_idle();
    w5300_int_n = 1'b0;
    @(negedge clk);
    check("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
`ifdef W5300_INT_SYNC_EN
    check("irq_assert", 32'(irq), 32'd1);
    @(negedge clk);
    check("int_pend_set", 32'(dbg.int_pend), 32'd1);
    single_access(OP_RD, IR_ADDR, 16'h0, 16'($urandom));
    @(negedge clk);
    check("int_pend_cleared", 32'(dbg.int_pend), 32'd0);
    check("irq_level_held", 32'(irq), 32'd1);
`else
    check("irq_tied_low", 32'(irq), 32'd0);
`endif

    do_reset();                      // interrupt pin still low while not ready
    w5300_int_n = 1'b1;

    repeat (6) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("op_state_total", op_state_cnt, n_issued);
    check("strobes_both_low", both_low, 0);
    check("strobe_without_cs", strobe_no_cs, 0);
    check("oe_while_cs_high", oe_idle, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
